regbank_write_arbiter: RTL and testbench
========================================

// Module: regbank_write_arbiter
// PURPOSE
//   Shares the single write port of the 8x16 register bank among N_REQ write-back
//   sources: ALU result, memory load and immediate/move.
//   Grants are round-robin with a req/ack handshake. Drives the bank's rd/Datain/
//   registerLoad from registers: outputs change on posedge clk and are stable when
//   the bank captures on negedge clk. Sits between the datapath sources and the bank.
// PARAMETERS
//   N_REQ   3   number of write requesters (index 0 = ALU, 1 = MEM, 2 = IMM)
//   DATA_W  16  register data width
//   ADDR_W  3   register index width (2**ADDR_W registers)
//   CNT_W   16  width of the committed-write counter
// PORTS
//   clk         in   1             system clock; all state updates on posedge
//   rst_n       in   1             asynchronous, active-low reset
//   stall       in   1             1 = issue no new grant this cycle
//   req         in   N_REQ         per-source write request; held until acked
//   req_rd      in   N_REQ*ADDR_W  per-source destination index, slice i = source i
//   req_data    in   N_REQ*DATA_W  per-source write data, slice i = source i
//   ack         out  N_REQ         one-hot, one-cycle pulse: source's write committed
//   rd          out  ADDR_W        to bank rd
//   Datain      out  DATA_W        to bank Datain
//   registerLoad out 1             to bank registerLoad
//   busy        out  1             1 while state == WRITE
//   wr_count    out  CNT_W         number of committed writes, wraps modulo 2**CNT_W
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, rr_ptr=0, ack=0, rd=0, Datain=0,
//     registerLoad=0, busy=0, wr_count=0. Deasserting mid-write drops that write.
//   Eligible set E (evaluated each posedge) = req & ~ack.
//     A source acked this cycle is not re-granted on the next edge, even if its
//     req is still high.
//   Winner = first set bit of E scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
//   FSM (2 states):
//     IDLE : if !stall && E!=0 -> WRITE. Register the winner's slices into rd/Datain,
//            set registerLoad=1, ack=onehot(winner), rr_ptr=(winner+1)%N_REQ,
//            wr_count+=1. Otherwise stay in IDLE with registerLoad=0 and ack=0.
//     WRITE: if !stall && E!=0 -> WRITE. Back-to-back grant with the same
//            updates as above.
//            Otherwise -> IDLE with registerLoad=0 and ack=0.
//   Latency: req sampled high at edge N -> registerLoad/ack high in cycle N..N+1.
//     The bank writes at the following negedge. One write per cycle maximum.
//   rd/Datain hold their last granted values when registerLoad=0 (no glitching).
//   Handshake: a source must hold req, req_rd and req_data stable until it sees
//     ack=1. At the edge ending the ack cycle it drops req or presents a new write.
//   stall=1 blocks only new grants. A write already registered completes, and the
//     FSM returns to IDLE on the stalled edge.
//   Same rd from two sources: both are written in grant order. The later grant
//     wins in the bank.
//   req high with stall held: no ack and no write; requests wait indefinitely.
//   Starvation-free: with continuous requests on all sources, each source is
//     granted at least once every N_REQ grants.
//   wr_count wraps from 2**CNT_W-1 to 0 without any flag.
// TESTING
//   1 Reset: drive rst_n=0 mid-WRITE -> all outputs 0 immediately, without waiting
//     for a clk edge.
//   2 Single write: req=001, rd0=5, data0=16'hBEEF -> one cycle later
//     registerLoad=1, rd=5, Datain=BEEF, ack=001. The bank reg5 reads BEEF after
//     the negedge.
//   3 All sources held requesting (req=111) for 6 grants -> ack sequence
//     001,010,100,001,010,100; registerLoad stays 1 and wr_count=6.
//   4 stall=1 with req=010 for 4 cycles -> ack=0 and registerLoad=0 throughout.
//     Release stall -> ack=010 on the next cycle.
//   5 Sources 0 and 2 both target rd=3 with data 1111 and 2222, rr_ptr=0 ->
//     grants in order 0 then 2; the bank reg3 ends at 2222.
//   6 Source holds req one cycle after its ack -> not re-granted that edge.
//     Verify no duplicate write and that wr_count increments exactly once.

Source files
------------

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter sharing the register bank's single write port among N_REQ
// write-back sources; bank-facing outputs are registered so they are stable at the negedge.
module regbank_write_arbiter #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_rd,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  output logic [ADDR_W-1:0]         rd,
  output logic [DATA_W-1:0]         Datain,
  output logic                      registerLoad,
  output logic                      busy,
  output logic [CNT_W-1:0]          wr_count
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t             state, state_d;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_d;
  logic [N_REQ-1:0]   elig;
  logic [N_REQ-1:0]   ack_d;
  logic [ADDR_W-1:0]  rd_d;
  logic [DATA_W-1:0]  datain_d;
  logic               load_d;
  logic [CNT_W-1:0]   count_d;
  logic               found;
  int                 win;

  // A source acked this cycle is masked so a held req cannot be granted twice.
  assign elig = req & ~ack;
  assign busy = (state == WRITE);

  always_comb begin
    found = 1'b0;
    win   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Both states behave identically on a grant; without one the FSM settles in IDLE.
  always_comb begin
    state_d  = IDLE;
    rr_ptr_d = rr_ptr;
    ack_d    = '0;
    rd_d     = rd;
    datain_d = Datain;
    load_d   = 1'b0;
    count_d  = wr_count;
    case (state)
      IDLE, WRITE: begin
        if (!stall && found) begin
          state_d     = WRITE;
          rd_d        = req_rd[win*ADDR_W +: ADDR_W];
          datain_d    = req_data[win*DATA_W +: DATA_W];
          load_d      = 1'b1;
          ack_d[win]  = 1'b1;
          rr_ptr_d    = PTR_W'((win + 1) % N_REQ);
          count_d     = wr_count + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      ack          <= '0;
      rd           <= '0;
      Datain       <= '0;
      registerLoad <= 1'b0;
      wr_count     <= '0;
    end else begin
      state        <= state_d;
      rr_ptr       <= rr_ptr_d;
      ack          <= ack_d;
      rd           <= rd_d;
      Datain       <= datain_d;
      registerLoad <= load_d;
      wr_count     <= count_d;
    end
  end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed-vector bench for regbank_write_arbiter with a behavioural 8x16 bank
// that captures on the negedge, as the real bank does.
module tb_regbank_write_arbiter;

  localparam int N_REQ  = 3;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 16;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    stall;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_rd;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        ack;
  logic [ADDR_W-1:0]       rd;
  logic [DATA_W-1:0]       Datain;
  logic                    registerLoad;
  logic                    busy;
  logic [CNT_W-1:0]        wr_count;

  logic [DATA_W-1:0]       bank [8];
  int                      checkCount = 0;
  int                      errorCount = 0;

  regbank_write_arbiter #(
    .N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .req(req), .req_rd(req_rd),
    .req_data(req_data), .ack(ack), .rd(rd), .Datain(Datain),
    .registerLoad(registerLoad), .busy(busy), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (registerLoad) bank[rd] <= Datain;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [8:0] rds, input logic [47:0] dat, input logic st);
    req      = r;
    req_rd   = rds;
    req_data = dat;
    stall    = st;
  endtask

  // Inputs change and outputs are sampled just after the negedge, away from posedge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  logic [2:0] ackSeq [6];

  initial begin
    for (int i = 0; i < 8; i++) bank[i] = '0;
    ackSeq[0] = 3'b001; ackSeq[1] = 3'b010; ackSeq[2] = 3'b100;
    ackSeq[3] = 3'b001; ackSeq[4] = 3'b010; ackSeq[5] = 3'b100;

    rst_n = 1'b0;
    applyStimulus(3'b000, 9'd0, 48'd0, 1'b0);
    #12;
    checkOutput("reset_ack", 32'(ack), 32'h0);
    checkOutput("reset_load", 32'(registerLoad), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_count", 32'(wr_count), 32'h0);
    rst_n = 1'b1;

    // Single write from source 0
    applyStimulus(3'b001, {3'd0, 3'd0, 3'd5}, {16'h0, 16'h0, 16'hBEEF}, 1'b0);
    step();
    checkOutput("single_load", 32'(registerLoad), 32'h1);
    checkOutput("single_rd", 32'(rd), 32'h5);
    checkOutput("single_data", 32'(Datain), 32'hBEEF);
    checkOutput("single_ack", 32'(ack), 32'h1);
    checkOutput("single_busy", 32'(busy), 32'h1);
    checkOutput("single_count", 32'(wr_count), 32'h1);
    checkOutput("single_bank5", 32'(bank[5]), 32'hBEEF);
    applyStimulus(3'b000, {3'd0, 3'd0, 3'd5}, {16'h0, 16'h0, 16'hBEEF}, 1'b0);
    step();
    checkOutput("idle_load", 32'(registerLoad), 32'h0);
    checkOutput("idle_ack", 32'(ack), 32'h0);
    checkOutput("idle_busy", 32'(busy), 32'h0);
    checkOutput("hold_rd", 32'(rd), 32'h5);
    checkOutput("hold_data", 32'(Datain), 32'hBEEF);

    // Source 1 keeps req high through the cycle after its ack
    applyStimulus(3'b010, {3'd0, 3'd2, 3'd0}, {16'h0, 16'h1234, 16'h0}, 1'b0);
    step();
    checkOutput("held_ack", 32'(ack), 32'h2);
    checkOutput("held_count1", 32'(wr_count), 32'h2);
    step();
    checkOutput("held_noregrant_ack", 32'(ack), 32'h0);
    checkOutput("held_noregrant_load", 32'(registerLoad), 32'h0);
    checkOutput("held_count2", 32'(wr_count), 32'h2);
    checkOutput("held_bank2", 32'(bank[2]), 32'h1234);
    applyStimulus(3'b000, 9'd0, 48'd0, 1'b0);
    step();

    // All three sources requesting continuously
    pulseReset();
    checkOutput("rr_count_start", 32'(wr_count), 32'h0);
    applyStimulus(3'b111, {3'd3, 3'd2, 3'd1}, {16'hA2A2, 16'hA1A1, 16'hA0A0}, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      checkOutput($sformatf("rr_ack%0d", i), 32'(ack), 32'(ackSeq[i]));
      checkOutput($sformatf("rr_load%0d", i), 32'(registerLoad), 32'h1);
    end
    checkOutput("rr_count", 32'(wr_count), 32'h6);
    checkOutput("rr_bank3", 32'(bank[3]), 32'hA2A2);
    applyStimulus(3'b000, 9'd0, 48'd0, 1'b0);
    step();
    checkOutput("rr_end_load", 32'(registerLoad), 32'h0);

    // Stall blocks a pending request until released
    applyStimulus(3'b010, {3'd0, 3'd4, 3'd0}, {16'h0, 16'h5555, 16'h0}, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput($sformatf("stall_ack%0d", i), 32'(ack), 32'h0);
      checkOutput($sformatf("stall_load%0d", i), 32'(registerLoad), 32'h0);
    end
    stall = 1'b0;
    step();
    checkOutput("unstall_ack", 32'(ack), 32'h2);
    checkOutput("unstall_load", 32'(registerLoad), 32'h1);
    checkOutput("unstall_count", 32'(wr_count), 32'h7);
    applyStimulus(3'b000, 9'd0, 48'd0, 1'b0);
    step();

    // Two sources writing the same register: later grant wins
    pulseReset();
    applyStimulus(3'b101, {3'd3, 3'd0, 3'd3}, {16'h2222, 16'h0, 16'h1111}, 1'b0);
    step();
    checkOutput("same_ack0", 32'(ack), 32'h1);
    checkOutput("same_data0", 32'(Datain), 32'h1111);
    checkOutput("same_bank3_first", 32'(bank[3]), 32'h1111);
    req = 3'b100;
    step();
    checkOutput("same_ack2", 32'(ack), 32'h4);
    checkOutput("same_rd2", 32'(rd), 32'h3);
    req = 3'b000;
    step();
    checkOutput("same_bank3_final", 32'(bank[3]), 32'h2222);
    checkOutput("same_count", 32'(wr_count), 32'h2);

    // Asynchronous reset in the middle of a write
    applyStimulus(3'b111, {3'd1, 3'd1, 3'd6}, {16'h0, 16'h0, 16'hCAFE}, 1'b0);
    step();
    checkOutput("midrst_pre_busy", 32'(busy), 32'h1);
    checkOutput("midrst_pre_rd", 32'(rd), 32'h6);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ack", 32'(ack), 32'h0);
    checkOutput("midrst_rd", 32'(rd), 32'h0);
    checkOutput("midrst_data", 32'(Datain), 32'h0);
    checkOutput("midrst_load", 32'(registerLoad), 32'h0);
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    checkOutput("midrst_count", 32'(wr_count), 32'h0);
    applyStimulus(3'b000, 9'd0, 48'd0, 1'b0);
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
